adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
Autonomous multi-channel scan controller in front of the ADC128S102 serial driver.
- Issues one conversion per sample tick over the enabled channels in ascending order, wrapping after the highest.
- Drives the driver's channel address and start strobe, and captures its one-cycle result.
- Handles the ADC's one-frame address-to-data pipeline.
- Publishes per-channel latest results through a registered read port and a live sample stream.

Parameters:
SAMPLE_PERIOD, 2000, clk cycles between sample ticks (must exceed one driver frame, about 70 clk)
TIMEOUT_CYC, 256, max clk cycles from adc_conv_go to adc_conv_done (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_en  in  1  level; 1 = run scanning
ch_mask  in  8  channel enable bit per ADC input
adc_addr  out  3  channel address to driver; held stable between frames
adc_conv_go  out  1  one-clk start pulse to driver
adc_data  in  12  driver result; valid only while adc_conv_done=1
adc_conv_done  in  1  driver completion strobe
smp_valid  out  1  one-clk strobe: new result available
smp_ch  out  3  channel that smp_data belongs to
smp_data  out  12  converted value
rd_ch  in  3  result-file read address
rd_data  out  12  latest result for rd_ch; registered, 1-clk latency
busy  out  1  1 while any state other than IDLE
overrun  out  1  sticky; a tick was lost because the previous frame was unfinished
err_timeout  out  1  sticky; conversion timeout (optional feature)

Behaviour:
- Reset: clk and rst_n are decided as above. All outputs are 0, the state is IDLE, and the result file and tick counter are cleared.
- Tick counter: free-runs 0..SAMPLE_PERIOD-1 whenever the state is not IDLE. tick=1 when the count equals SAMPLE_PERIOD-1. The counter clears on entering PRIME.
- Latched mask:
  - mask_q is captured from ch_mask on leaving IDLE and at each scan wrap.
  - Mid-scan ch_mask changes are ignored until the next wrap.
- Pipeline rule: the ADC returns data for the address sent in the previous frame. The sequencer keeps prev_ch, and the result of each frame is tagged with prev_ch.
- States:
  - IDLE: leave when scan_en=1 and ch_mask!=0. Go to PRIME and set cur_ch to the lowest set bit of ch_mask.
  - PRIME: drive adc_addr=cur_ch and pulse adc_conv_go. Go to WAIT_DONE with discard=1, because the first frame's data is stale.
  - WAIT_TICK: on tick, drive adc_addr=cur_ch, pulse adc_conv_go, and go to WAIT_DONE.
  - WAIT_DONE: on adc_conv_done go to STORE, capturing adc_data into a holding register.
  - STORE (one clk):
    - If discard=0: write result[prev_ch], then in the next clk pulse smp_valid with smp_ch=prev_ch and smp_data.
    - Clear discard.
    - Set prev_ch=cur_ch and advance cur_ch to the next set bit of mask_q above it. If none, wrap to the lowest set bit and relatch mask_q.
    - If scan_en=0 or the relatched mask is 0: go to IDLE. Otherwise go to WAIT_TICK, or straight to the issue step if a tick is pending.
- Tick during WAIT_DONE/STORE: sets pending (one deep). A second tick while pending is already set sets overrun. pending clears when the frame issues.
- Single-channel mask: cur_ch equals prev_ch every frame. This is legal.
- scan_en dropping mid-frame: the frame completes and its result is stored, then the block returns to IDLE. Re-enabling re-primes, and that first result is discarded.
- adc_conv_done outside WAIT_DONE is ignored.
- The sticky flags overrun and err_timeout clear only on reset or on the IDLE-to-PRIME transition.
- Asynchronous reset mid-frame: immediate return to IDLE. The driver's own reset restores it.

Optional Feature:
ADC_SCAN_TIMEOUT_EN
- Defined:
  - A watchdog counts in WAIT_DONE.
  - At TIMEOUT_CYC with no adc_conv_done, err_timeout is set and the state returns to IDLE. If scan_en is still 1 the block re-primes and discards the next result.
- Undefined:
  - WAIT_DONE waits indefinitely.
  - err_timeout is tied to 0 and TIMEOUT_CYC is unused.

Decomposition:
- Package adc_scan_pkg holds:
  - the state encoding (IDLE, PRIME, WAIT_TICK, WAIT_DONE, STORE)
  - NUM_CH=8, CH_W=3, DATA_W=12
- One sub-module, adc_next_ch: combinational priority finder that returns the next set bit of mask above the current channel with wrap, plus a wrap flag.
- The result file is an inline 8x12 register array.

Test Plan:
1. ch_mask=8'b0000_0101, scan_en=1, ADC model returns 12'h100+addr of previous frame:
   - the first result is discarded (no smp_valid);
   - then smp_ch sequence 0,2,0,2 with data 12'h100, 12'h102, and so on;
   - rd_ch=2 gives 12'h102 one clk later.
2. ch_mask=8'h80 only: every frame has adc_addr=7; smp_ch=7 from the second frame onward.
3. Drop scan_en during WAIT_DONE: the current result is stored, smp_valid pulses once, then IDLE with busy=0; re-enable causes one further discarded frame.
4. SAMPLE_PERIOD=50, shorter than the driver frame:
   - overrun=1 after the second lost tick;
   - the scan order is still correct;
   - overrun clears on the next IDLE-to-PRIME.
5. With ADC_SCAN_TIMEOUT_EN and TIMEOUT_CYC=100, suppress adc_conv_done: err_timeout=1 at cycle 100 after adc_conv_go, then a re-prime with a discarded frame follows.
6. Assert rst_n=0 mid-WAIT_DONE: all outputs are 0 and the result file is cleared; ch_mask=0 with scan_en=1 keeps the block in IDLE with no adc_conv_go.

Source files
------------

// File: rtl/adc_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_pkg
// Description : Shared types and constants for the ADC scan sequencer:
//               state encoding, channel/data widths and a lowest-set-bit
//               helper used when (re)starting a scan.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME     = 3'd1,
    WAIT_TICK = 3'd2,
    WAIT_DONE = 3'd3,
    STORE     = 3'd4
  } state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = CH_W'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_next_ch.sv
`default_nettype none
// ============================================================================
// Module      : adc_next_ch
// Description : Combinational priority finder. Returns the next set bit of
//               mask strictly above cur_ch; when none exists it returns the
//               lowest set bit and raises wrap.
// Ports       : mask    in  [NUM_CH-1:0] channel enable mask
//               cur_ch  in  [CH_W-1:0]   current channel
//               next_ch out [CH_W-1:0]   next channel to convert
//               wrap    out              1 = no higher channel, scan wraps
// Revision    : 1.0 - initial release
// ============================================================================
module adc_next_ch
  import adc_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic              wrap
);

  // Descending scan so the lowest qualifying bit is the last one written.
  always_comb begin
    next_ch = lowest_set(mask);
    wrap    = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (CH_W'(i) > cur_ch)) begin
        next_ch = CH_W'(i);
        wrap    = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_sequencer
// Description : Autonomous multi-channel scan controller in front of the
//               ADC128S102 serial driver. One conversion per sample tick over
//               the enabled channels in ascending order. The ADC returns data
//               for the address of the previous frame, so every result is
//               tagged with prev_ch and the first frame after a prime is
//               discarded.
// Optional    : ADC_SCAN_TIMEOUT_EN - conversion watchdog (TIMEOUT_CYC) that
//               sets err_timeout and re-primes. Undefined: err_timeout = 0.
// Ports       : clk, rst_n (async, active-low)
//               scan_en, ch_mask            scan control
//               adc_addr, adc_conv_go       to driver
//               adc_data, adc_conv_done     from driver
//               smp_valid, smp_ch, smp_data live sample stream
//               rd_ch -> rd_data            result file read, 1-clk latency
//               busy, overrun, err_timeout  status
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 2000,
  parameter int TIMEOUT_CYC   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [CH_W-1:0]   adc_addr,
  output logic              adc_conv_go,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_conv_done,
  output logic              smp_valid,
  output logic [CH_W-1:0]   smp_ch,
  output logic [DATA_W-1:0] smp_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              overrun,
  output logic              err_timeout
);

  localparam int              CNT_W     = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]     prev_ch_q, prev_ch_d;
  logic [CH_W-1:0]     addr_q, addr_d;
  logic                discard_q, discard_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                smp_valid_q, smp_valid_d;
  logic [CH_W-1:0]     smp_ch_q, smp_ch_d;
  logic [DATA_W-1:0]   smp_data_q, smp_data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   result_q [NUM_CH];
  logic [DATA_W-1:0]   result_d [NUM_CH];

  logic                tick;
  logic                start;
  logic                issue;
  logic                wd_expire;
  logic                stop;
  logic [CH_W-1:0]     nxt_ch;
  logic                nxt_wrap;

  adc_next_ch u_next_ch (
    .mask    (mask_q),
    .cur_ch  (cur_ch_q),
    .next_ch (nxt_ch),
    .wrap    (nxt_wrap)
  );

  assign tick  = (state_q != IDLE) && (cnt_q == TICK_LAST);
  assign start = (state_q == IDLE) && scan_en && (|ch_mask);
  // On wrap the mask is relatched, so an all-zero ch_mask ends the scan.
  assign stop  = !scan_en || (nxt_wrap && (ch_mask == '0));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = PRIME;
      PRIME:     state_d = WAIT_DONE;
      // No frame is in flight while waiting, so disabling exits at once.
      WAIT_TICK: if (!scan_en)              state_d = IDLE;
                 else if (tick || pending_q) state_d = WAIT_DONE;
      WAIT_DONE: if (adc_conv_done)   state_d = STORE;
                 else if (wd_expire)  state_d = IDLE;
      STORE:     state_d = stop ? IDLE : WAIT_TICK;
      default:   state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    issue = (state_q == PRIME) ||
            ((state_q == WAIT_TICK) && scan_en && (tick || pending_q));
    adc_conv_go = issue;
    // Address follows cur_ch on the issue cycle and is then held.
    adc_addr    = issue ? cur_ch_q : addr_q;
    busy        = (state_q != IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    cur_ch_d    = cur_ch_q;
    prev_ch_d   = prev_ch_q;
    addr_d      = addr_q;
    discard_d   = discard_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    hold_d      = hold_q;
    smp_valid_d = 1'b0;
    smp_ch_d    = smp_ch_q;
    smp_data_d  = smp_data_q;
    result_d    = result_q;
    rd_data_d   = result_q[rd_ch];

    if (start) begin
      cnt_d     = '0;
      mask_d    = ch_mask;
      cur_ch_d  = lowest_set(ch_mask);
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end else if (state_q != IDLE) begin
      cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    if (state_q == PRIME) discard_d = 1'b1;

    if (issue) begin
      addr_d    = cur_ch_q;
      pending_d = 1'b0;
    end

    // One-deep tick memory while a frame is outstanding.
    if (tick && ((state_q == WAIT_DONE) || (state_q == STORE))) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    if ((state_q == WAIT_DONE) && adc_conv_done) hold_d = adc_data;

    if (state_q == STORE) begin
      if (!discard_q) begin
        result_d[prev_ch_q] = hold_q;
        smp_valid_d         = 1'b1;
        smp_ch_d            = prev_ch_q;
        smp_data_d          = hold_q;
      end
      discard_d = 1'b0;
      prev_ch_d = cur_ch_q;
      if (nxt_wrap) begin
        mask_d   = ch_mask;
        cur_ch_d = lowest_set(ch_mask);
      end else begin
        cur_ch_d = nxt_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mask_q      <= '0;
      cur_ch_q    <= '0;
      prev_ch_q   <= '0;
      addr_q      <= '0;
      discard_q   <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      hold_q      <= '0;
      smp_valid_q <= 1'b0;
      smp_ch_q    <= '0;
      smp_data_q  <= '0;
      rd_data_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      cur_ch_q    <= cur_ch_d;
      prev_ch_q   <= prev_ch_d;
      addr_q      <= addr_d;
      discard_q   <= discard_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      hold_q      <= hold_d;
      smp_valid_q <= smp_valid_d;
      smp_ch_q    <= smp_ch_d;
      smp_data_q  <= smp_data_d;
      rd_data_q   <= rd_data_d;
      result_q    <= result_d;
    end
  end

  assign smp_valid = smp_valid_q;
  assign smp_ch    = smp_ch_q;
  assign smp_data  = smp_data_q;
  assign rd_data   = rd_data_q;
  assign overrun   = overrun_q;

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_timeout_q, err_timeout_d;
  logic            retry_q, retry_d;

  // wd_q equals the number of cycles since adc_conv_go, so the flag becomes
  // visible exactly TIMEOUT_CYC cycles after the start pulse.
  assign wd_expire = (state_q == WAIT_DONE) && !adc_conv_done &&
                     (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d          = wd_q;
    err_timeout_d = err_timeout_q;
    retry_d       = retry_q;
    if (issue)                     wd_d = WD_W'(1);
    else if (state_q == WAIT_DONE) wd_d = wd_q + WD_W'(1);
    if (wd_expire) begin
      err_timeout_d = 1'b1;
      retry_d       = 1'b1;
    end else if (start) begin
      // The automatic re-prime after a timeout must keep the flag visible.
      if (!retry_q) err_timeout_d = 1'b0;
      retry_d = 1'b0;
    end else if (state_q == IDLE) begin
      retry_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
      retry_q       <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
      retry_q       <= retry_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_sequencer
// Description : Scoreboard bench for adc_scan_sequencer with a pipelined
//               ADC driver model (data = 12'h100 + previous frame address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

  localparam int SP = 50;
  localparam int TO = 100;

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic [7:0]  ch_mask;
  logic [2:0]  adc_addr;
  logic        adc_conv_go;
  logic [11:0] adc_data;
  logic        adc_conv_done;
  logic        smp_valid;
  logic [2:0]  smp_ch;
  logic [11:0] smp_data;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic        busy;
  logic        overrun;
  logic        err_timeout;

  adc_scan_sequencer #(.SAMPLE_PERIOD(SP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
    .adc_addr(adc_addr), .adc_conv_go(adc_conv_go), .adc_data(adc_data),
    .adc_conv_done(adc_conv_done), .smp_valid(smp_valid), .smp_ch(smp_ch),
    .smp_data(smp_data), .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy),
    .overrun(overrun), .err_timeout(err_timeout)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [14:0] exp_q[$];
  logic [2:0]  go_log[$];
  int          go_cnt   = 0;
  int          go_cyc   = 0;
  int          lat      = 20;
  bit          suppress = 0;
  bit          kick     = 0;
  logic [2:0]  last_addr = 3'd5;
  logic [2:0]  prev_addr = 3'd5;
  int          cd = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] ch, input logic [11:0] data);
    exp_q.push_back({ch, data});
  endtask

  // ADC driver model: returns 12'h100 + address of the previous frame.
  initial begin
    adc_conv_done = 1'b0;
    adc_data      = '0;
    forever begin
      @(negedge clk);
      adc_conv_done = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (kick) begin
          adc_conv_done = 1'b1;
          adc_data      = 12'h100 + 12'(prev_addr);
          kick          = 0;
        end else if (cd > 0) begin
          cd--;
          if (cd == 0 && !suppress) begin
            adc_conv_done = 1'b1;
            adc_data      = 12'h100 + 12'(prev_addr);
          end
        end
        if (adc_conv_go) begin
          go_log.push_back(adc_addr);
          go_cnt++;
          go_cyc    = cyc;
          prev_addr = last_addr;
          last_addr = adc_addr;
          cd        = lat;
        end
      end
    end
  end

  // Monitor: every smp_valid must match the head of the expected queue.
  initial forever begin
    logic [14:0] e;
    @(negedge clk);
    if (rst_n && smp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got ch %0d data 0x%0h expected none (cycle %0d)",
                 smp_ch, smp_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("smp_ch", smp_ch, e[14:12]);
        check("smp_data", smp_data, e[11:0]);
      end
    end
  end

  task automatic wait_gos(input int base, input int n_go);
    int n = 0;
    while (go_cnt < base + n_go && n < n_go * 200 + 300) begin
      @(negedge clk);
      n++;
    end
    check("frames_issued", go_cnt - base, n_go);
  endtask

  // Let n_go frames issue, drop scan_en while the last is in flight, drain.
  task automatic finish_scan(input int base, input int n_go);
    int n = 0;
    wait_gos(base, n_go);
    @(negedge clk);
    scan_en = 1'b0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("busy_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic scan_frames(input logic [7:0] mask, input int n_go, input int lat_cfg);
    int base;
    lat     = lat_cfg;
    ch_mask = mask;
    go_log.delete();
    base    = go_cnt;
    scan_en = 1'b1;
    finish_scan(base, n_go);
  endtask

  initial begin
    int base;
    int n;
    rst_n   = 1'b0;
    scan_en = 1'b0;
    ch_mask = '0;
    rd_ch   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_go", adc_conv_go, 0);
    check("rst_smp_valid", smp_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_rd_data", rd_data, 0);

    // Two-channel scan: first frame discarded, tags follow previous address
    push(3'd0, 12'h100); push(3'd2, 12'h102);
    push(3'd0, 12'h100); push(3'd2, 12'h102);
    scan_frames(8'h05, 5, 20);
    check("t1_go_count", go_log.size(), 5);
    for (int i = 0; i < 5 && i < go_log.size(); i++)
      check("t1_go_addr", go_log[i], (i % 2 == 0) ? 0 : 2);

    // Result file read port
    rd_ch = 3'd2; @(negedge clk); check("rd_ch2", rd_data, 12'h102);
    rd_ch = 3'd0; @(negedge clk); check("rd_ch0", rd_data, 12'h100);
    rd_ch = 3'd1; @(negedge clk); check("rd_ch1", rd_data, 12'h000);

    // scan_en dropped in WAIT_DONE: that frame is stored, then re-prime discards
    push(3'd0, 12'h100);
    scan_frames(8'h05, 2, 20);
    push(3'd0, 12'h100);
    scan_frames(8'h05, 2, 20);
    check("t3_reprime_addr0", go_log[0], 0);
    check("t3_reprime_addr1", go_log[1], 2);

    // Frames longer than the sample period: overrun, order preserved
    push(3'd0, 12'h100); push(3'd2, 12'h102);
    push(3'd0, 12'h100); push(3'd2, 12'h102);
    scan_frames(8'h05, 5, 70);
    check("t4_overrun", overrun, 1);
    for (int i = 0; i < 5 && i < go_log.size(); i++)
      check("t4_go_addr", go_log[i], (i % 2 == 0) ? 0 : 2);

    // Single channel 7; overrun cleared by the new prime
    push(3'd7, 12'h107); push(3'd7, 12'h107); push(3'd7, 12'h107);
    scan_frames(8'h80, 4, 20);
    check("t2_overrun_cleared", overrun, 0);
    for (int i = 0; i < go_log.size(); i++)
      check("t2_go_addr", go_log[i], 7);

`ifdef ADC_SCAN_TIMEOUT_EN
    // Watchdog: err_timeout TIMEOUT_CYC after go, then re-prime
    lat = 20; suppress = 1; ch_mask = 8'h01; go_log.delete();
    push(3'd0, 12'h100);
    base = go_cnt;
    scan_en = 1'b1;
    wait_gos(base, 1);
    n = 0;
    while (!err_timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout_latency", cyc - go_cyc, TO);
    suppress = 0;
    finish_scan(base, 3);
    check("t5_err_sticky", err_timeout, 1);
`else
    // Without the watchdog a missing done stalls WAIT_DONE indefinitely
    lat = 20; suppress = 1; ch_mask = 8'h01; go_log.delete();
    push(3'd0, 12'h100);
    base = go_cnt;
    scan_en = 1'b1;
    repeat (300) @(negedge clk);
    check("t5_stall_busy", busy, 1);
    check("t5_stall_err", err_timeout, 0);
    check("t5_stall_go", go_cnt - base, 1);
    check("t5_stall_overrun", overrun, 1);
    suppress = 0;
    kick = 1;
    finish_scan(base, 2);
`endif

    // Asynchronous reset mid-frame
    rd_ch = 3'd7; @(negedge clk); check("t6_rd_ch7_before", rd_data, 12'h107);
    lat = 20; ch_mask = 8'h05;
    base = go_cnt;
    scan_en = 1'b1;
    wait_gos(base, 1);
    repeat (5) @(negedge clk);
    rst_n   = 1'b0;
    ch_mask = 8'h00;
    #1;
    check("t6_busy", busy, 0);
    check("t6_go", adc_conv_go, 0);
    check("t6_addr", adc_addr, 0);
    check("t6_smp_valid", smp_valid, 0);
    check("t6_smp_ch", smp_ch, 0);
    check("t6_smp_data", smp_data, 0);
    check("t6_rd_data", rd_data, 0);
    check("t6_overrun", overrun, 0);
    check("t6_err", err_timeout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_ch = 3'd0; @(negedge clk); check("t6_rd_ch0", rd_data, 0);
    rd_ch = 3'd2; @(negedge clk); check("t6_rd_ch2", rd_data, 0);
    rd_ch = 3'd7; @(negedge clk); check("t6_rd_ch7", rd_data, 0);
    base = go_cnt;
    repeat (40) @(negedge clk);
    check("t6_no_go_empty_mask", go_cnt - base, 0);
    check("t6_idle_empty_mask", busy, 0);
    scan_en = 1'b0;
    check("t6_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
